// File: rtl/key_scan_if.sv
// Keypad matrix bundle: row sense lines in, column drive and decoded key out.
interface key_scan_if;
  logic [3:0] row;
  logic [3:0] col_index;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col_index,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col_index,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/key_scan.sv
// 4x4 keypad column scanner with debounced press/release detection.
// One key is tracked at a time; the column freezes while that key is debounced or held.
module key_scan #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk_key,
  input  logic       rst,
  key_scan_if.master kp
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_nxt;
  logic [3:0]       sync1_q, rs;
  logic [3:0]       col_q, col_nxt;
  logic [1:0]       col_idx_q, col_idx_nxt;
  logic [CNT_W-1:0] dwell_q, dwell_nxt;
  logic [CNT_W-1:0] stab_q, stab_nxt;
  logic [1:0]       cand_q, cand_nxt;
  logic [3:0]       code_q, code_nxt;
  logic             valid_q, valid_nxt;
  logic             held_q, held_nxt;
  logic [1:0]       low_row;
  logic             cand_up;

  // Lowest-indexed row pulled low wins when several rows are active
  always_comb begin
    casez (rs)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  end

  assign cand_up = rs[cand_q];

  always_ff @(posedge clk_key) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      sync1_q   <= 4'hF;
      rs        <= 4'hF;
      col_q     <= 4'b1110;
      col_idx_q <= 2'd0;
      dwell_q   <= '0;
      stab_q    <= '0;
      cand_q    <= 2'd0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      sync1_q   <= kp.row;
      rs        <= sync1_q;
      col_q     <= col_nxt;
      col_idx_q <= col_idx_nxt;
      dwell_q   <= dwell_nxt;
      stab_q    <= stab_nxt;
      cand_q    <= cand_nxt;
      code_q    <= code_nxt;
      valid_q   <= valid_nxt;
      held_q    <= held_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    col_nxt     = col_q;
    col_idx_nxt = col_idx_q;
    dwell_nxt   = dwell_q;
    stab_nxt    = stab_q;
    cand_nxt    = cand_q;
    code_nxt    = code_q;
    valid_nxt   = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_nxt = '0;
          if (rs == 4'hF) begin
            col_nxt     = {col_q[2:0], col_q[3]};
            col_idx_nxt = col_idx_q + 2'd1;
          end else begin
            cand_nxt  = low_row;
            stab_nxt  = '0;
            state_nxt = ST_DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell_q + CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!cand_up) begin
          if (stab_q == STAB_LAST) begin
            state_nxt = ST_PRESSED;
            code_nxt  = {cand_q, col_idx_q};
            valid_nxt = 1'b1;
          end else begin
            stab_nxt = stab_q + CNT_W'(1);
          end
        end else begin
          // Bounce: resume scanning past the column that glitched
          state_nxt   = ST_SCAN;
          col_nxt     = {col_q[2:0], col_q[3]};
          col_idx_nxt = col_idx_q + 2'd1;
          dwell_nxt   = '0;
        end
      end
      ST_PRESSED: begin
        if (cand_up) begin
          state_nxt = ST_RELEASE;
          stab_nxt  = '0;
        end
      end
      ST_RELEASE: begin
        if (cand_up) begin
          if (stab_q == STAB_LAST) begin
            state_nxt   = ST_SCAN;
            col_nxt     = {col_q[2:0], col_q[3]};
            col_idx_nxt = col_idx_q + 2'd1;
            dwell_nxt   = '0;
          end else begin
            stab_nxt = stab_q + CNT_W'(1);
          end
        end else begin
          state_nxt = ST_PRESSED;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase

    held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE);
  end

  assign kp.col_index = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule
